// File: rtl/combination_key_sender.sv
// combination_key_sender: sends a resync preamble followed by the stored code bit-serially,
// then checks the lock's unlock feedback and retries up to MAX_TRY attempts.
module combination_key_sender #(
    parameter int                  CODE_LEN = 7,
    parameter logic [CODE_LEN-1:0] CODE     = 7'b0110111,
    parameter int                  PRE_LEN  = 4,
    parameter int                  MAX_TRY  = 3
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                start_i,
    input  logic                load_i,
    input  logic [CODE_LEN-1:0] code_in_i,
    input  logic                unlk_in_i,
    output logic                x_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                fail_o,
    output logic [1:0]          tries_o
);
    localparam int CW = $clog2(PRE_LEN > CODE_LEN ? PRE_LEN : CODE_LEN);
    localparam int AW = $clog2(MAX_TRY + 1) + 1;

    typedef enum logic [1:0] {IDLE, PRE, SEND, CHECK} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CODE_LEN-1:0] sh_q, sh_d;
    logic [AW-1:0]       att_q, att_d;
    logic                x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;

    // x is registered, so it is computed from the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        sh_d    = sh_q;
        att_d   = att_q;
        x_d     = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_i) code_d = code_in_i;
                if (start_i) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    att_d   = AW'(1);
                    busy_d  = 1'b1;
                end
            end
            PRE: begin
                if (cnt_q == CW'(PRE_LEN - 1)) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    x_d     = code_q[CODE_LEN-1];
                    sh_d    = code_q << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == CW'(CODE_LEN - 1)) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    x_d   = sh_q[CODE_LEN-1];
                    sh_d  = sh_q << 1;
                end
            end
            CHECK: begin
                if (unlk_in_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (att_q < AW'(MAX_TRY)) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    att_d   = att_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= CODE;
            sh_q    <= '0;
            att_q   <= '0;
            x_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            sh_q    <= sh_d;
            att_q   <= att_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign x_o     = x_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign fail_o  = fail_q;
    assign tries_o = att_q > AW'(3) ? 2'd3 : att_q[1:0];
endmodule
